// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - requester-side request/response bus of mem_arbiter
// Purpose: bundles the per-port request and response handshakes shared between
//          the requesters (master) and the arbiter (slave).
// Signals:
//   req_valid/req_ready   N_REQ       request handshake, one bit per port
//   req_addr, req_wdata   32*N_REQ    byte address / write data, port i = [32i+31:32i]
//   req_wr_mask           2*N_REQ     0=none 1=byte 2=half 3=word
//   req_rd_mask           3*N_REQ     0=W 1=HZ 2=BZ 3=HE 4=BE (reads only)
//   rsp_valid/rsp_ready   N_REQ       response handshake, rsp_valid one-hot
//   rsp_data, rsp_err     32, 1       shared response payload
interface mem_arbiter_if #(
  parameter int N_REQ = 2
);
  logic [N_REQ-1:0]   req_valid;
  logic [N_REQ-1:0]   req_ready;
  logic [32*N_REQ-1:0] req_addr;
  logic [32*N_REQ-1:0] req_wdata;
  logic [2*N_REQ-1:0] req_wr_mask;
  logic [3*N_REQ-1:0] req_rd_mask;
  logic [N_REQ-1:0]   rsp_valid;
  logic [N_REQ-1:0]   rsp_ready;
  logic [31:0]        rsp_data;
  logic               rsp_err;

  modport master (
    output req_valid, req_addr, req_wdata, req_wr_mask, req_rd_mask, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_err
  );

  modport slave (
    input  req_valid, req_addr, req_wdata, req_wr_mask, req_rd_mask, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_err
  );
endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin arbiter sharing one byte-lane memory port
// Purpose: grants one of N_REQ requesters at a time, checks alignment and read
//          mask before touching memory, runs IDLE->ACCESS->DATA->RESP per access
//          (errors short-cut IDLE->RESP).
// Ports:
//   i_clk, i_reset_n        clock, asynchronous active-low reset
//   bus (slave)             requester request/response handshakes
//   o_mem_address/wr_data   memory address and write data (hold last latched value)
//   o_mem_wr_mask/rd_mask   memory strobes, non-zero only in ACCESS
//   i_mem_rd_data           registered read data, valid in DATA
//   i_mem_err_misaligned,
//   i_mem_err_rd_mask       registered memory error flags, valid in DATA
module mem_arbiter #(
  parameter int N_REQ = 2
) (
  input  logic         i_clk,
  input  logic         i_reset_n,
  mem_arbiter_if.slave bus,
  output logic [31:0]  o_mem_address,
  output logic [31:0]  o_mem_wr_data,
  output logic [1:0]   o_mem_wr_mask,
  output logic [2:0]   o_mem_rd_mask,
  input  logic [31:0]  i_mem_rd_data,
  input  logic         i_mem_err_misaligned,
  input  logic         i_mem_err_rd_mask
);
  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {IDLE, ACCESS, DATA, RESP} state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] rr_q;
  logic [PW-1:0] port_q;
  logic [31:0]   addr_q, wdata_q;
  logic [1:0]    wr_mask_q;
  logic [2:0]    rd_mask_q;
  logic [31:0]   rsp_data_q;
  logic          rsp_err_q;

  logic          grant_found;
  logic [PW-1:0] grant_id;
  int            gsel;
  logic [31:0]   g_addr, g_wdata;
  logic [1:0]    g_wr_mask;
  logic [2:0]    g_rd_mask;
  logic          g_err;
  logic          accept;

  function automatic logic access_err(input logic [1:0] wm, input logic [2:0] rm,
                                      input logic [1:0] a);
    logic word_acc, half_acc;
    word_acc = (wm == 2'd3) || (wm == 2'd0 && rm == 3'd0);
    half_acc = (wm == 2'd2) || (wm == 2'd0 && (rm == 3'd1 || rm == 3'd3));
    access_err = (word_acc && a != 2'd0) || (half_acc && a[0]) ||
                 (wm == 2'd0 && rm > 3'd4);
  endfunction

  // Search starts one past the last winner, so a port that just got served
  // goes to the back of the line.
  always_comb begin
    grant_found = 1'b0;
    grant_id    = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      if (!grant_found && bus.req_valid[(int'(rr_q) + k) % N_REQ]) begin
        grant_found = 1'b1;
        grant_id    = PW'((int'(rr_q) + k) % N_REQ);
      end
    end
  end

  always_comb begin
    gsel      = int'(grant_id);
    g_addr    = bus.req_addr[gsel*32 +: 32];
    g_wdata   = bus.req_wdata[gsel*32 +: 32];
    g_wr_mask = bus.req_wr_mask[gsel*2 +: 2];
    g_rd_mask = bus.req_rd_mask[gsel*3 +: 3];
    g_err     = access_err(g_wr_mask, g_rd_mask, g_addr[1:0]);
  end

  assign accept = (state_q == IDLE) && grant_found;

  always_comb begin
    bus.req_ready = '0;
    if (accept) bus.req_ready = N_REQ'(1) << grant_id;
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) state_q <= IDLE;
    else            state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = g_err ? RESP : ACCESS;
      ACCESS:  state_d = DATA;
      DATA:    state_d = RESP;
      RESP:    if (bus.rsp_ready[port_q]) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      rr_q       <= PW'(N_REQ - 1);
      port_q     <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wr_mask_q  <= '0;
      rd_mask_q  <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else if (accept) begin
      rr_q       <= grant_id;
      port_q     <= grant_id;
      addr_q     <= g_addr;
      wdata_q    <= g_wdata;
      wr_mask_q  <= g_wr_mask;
      rd_mask_q  <= g_rd_mask;
      rsp_data_q <= '0;
      rsp_err_q  <= g_err;
    end else if (state_q == DATA) begin
      rsp_data_q <= (wr_mask_q != 2'd0) ? 32'd0 : i_mem_rd_data;
      rsp_err_q  <= i_mem_err_misaligned | i_mem_err_rd_mask;
    end
  end

  // Strobes decode from state so they drop the instant reset asserts, which
  // is what cancels a write whose clock edge has not yet arrived.
  assign o_mem_address = addr_q;
  assign o_mem_wr_data = wdata_q;
  assign o_mem_wr_mask = (state_q == ACCESS) ? wr_mask_q : 2'd0;
  assign o_mem_rd_mask = (state_q == ACCESS && wr_mask_q == 2'd0) ? rd_mask_q : 3'd0;

  assign bus.rsp_valid = (state_q == RESP) ? (N_REQ'(1) << port_q) : '0;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_err   = rsp_err_q;
endmodule
